// File: rtl/ex_muldiv_if.sv
// ID/EX-side bundle for the RV32M unit: pipeline register inputs plus the
// stall request and the register-file write port.
interface ex_muldiv_if;
    logic [31:0] inst;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd_addr;
    logic        rd_wen;
    logic        flush;
    logic        hold;
    logic [31:0] rd_data;
    logic [4:0]  rd_addr_o;
    logic        rd_wen_o;

    modport master (
        output inst, op1, op2, rd_addr, rd_wen, flush,
        input  hold, rd_data, rd_addr_o, rd_wen_o
    );

    modport slave (
        input  inst, op1, op2, rd_addr, rd_wen, flush,
        output hold, rd_data, rd_addr_o, rd_wen_o
    );
endinterface

// File: rtl/ex_muldiv.sv
// RV32M multiply/divide for the execute stage: single-cycle registered multiply,
// 32-cycle restoring divide, one register-file write per M-op.
module ex_muldiv (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    ex_muldiv_if.slave io
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t      state, state_nx;
    logic [31:0] a_q, b_q, res_q, rem_q, quo_q, dvs_q;
    logic [2:0]  f3_q;
    logic [4:0]  rda_q, cnt_q;
    logic        rdw_q;

    logic        mop, start, in_zero, in_ovf, in_special, in_sgn;
    logic [2:0]  f3_in;
    logic [31:0] special_res;
    logic        unused_inst;

    assign unused_inst = ^{io.inst[24:15], io.inst[11:7]};

    assign mop        = (io.inst[6:0] == 7'b0110011) && (io.inst[31:25] == 7'b0000001);
    assign f3_in      = io.inst[14:12];
    assign start      = (state == S_IDLE) && mop && !io.flush;
    assign in_sgn     = ~f3_in[0];
    assign in_zero    = (io.op2 == 32'd0);
    assign in_ovf     = in_sgn && (io.op1 == 32'h8000_0000) && (io.op2 == 32'hFFFF_FFFF);
    assign in_special = f3_in[2] && (in_zero || in_ovf);
    // f3[1] distinguishes REM/REMU from DIV/DIVU
    assign special_res = in_zero ? (f3_in[1] ? io.op1 : 32'hFFFF_FFFF)
                                 : (f3_in[1] ? 32'd0  : 32'h8000_0000);

    // Multiply: 33-bit extension picks signed/unsigned per operand.
    logic signed [32:0] ma, mb;
    logic signed [65:0] prod;
    assign ma   = {(f3_q[1:0] != 2'b11) & a_q[31], a_q};
    assign mb   = {(f3_q[1] == 1'b0) & b_q[31], b_q};
    assign prod = ma * mb;

    // Restoring divide step: dividend bits shift out of quo_q as quotient bits shift in.
    logic [32:0] trial;
    logic        q_bit, d_sgn, q_neg, r_neg;
    logic [31:0] rem_nx, quo_nx, div_res;
    assign trial   = {rem_q, quo_q[31]} - {1'b0, dvs_q};
    assign q_bit   = ~trial[32];
    assign rem_nx  = q_bit ? trial[31:0] : {rem_q[30:0], quo_q[31]};
    assign quo_nx  = {quo_q[30:0], q_bit};
    assign d_sgn   = ~f3_q[0];
    assign q_neg   = d_sgn & (a_q[31] ^ b_q[31]);
    assign r_neg   = d_sgn & a_q[31];
    assign div_res = f3_q[1] ? (r_neg ? -rem_nx : rem_nx)
                             : (q_neg ? -quo_nx : quo_nx);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= S_IDLE;
        else            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start) state_nx = !f3_in[2] ? S_MUL : (in_special ? S_DONE : S_DIV);
            S_MUL:  state_nx = S_DONE;
            S_DIV:  if (cnt_q == 5'd31) state_nx = S_DONE;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // hold is forced low while reset is asserted so the stall releases at once.
    always_comb begin
        io.hold      = sys_rst_n && (start || (state == S_MUL) || (state == S_DIV));
        io.rd_wen_o  = 1'b0;
        io.rd_addr_o = 5'd0;
        io.rd_data   = 32'd0;
        if (state == S_DONE) begin
            io.rd_wen_o  = rdw_q;
            io.rd_addr_o = rda_q;
            io.rd_data   = res_q;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            f3_q  <= '0;
            rda_q <= '0;
            rdw_q <= 1'b0;
            res_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    a_q   <= io.op1;
                    b_q   <= io.op2;
                    f3_q  <= f3_in;
                    rda_q <= io.rd_addr;
                    rdw_q <= io.rd_wen;
                    res_q <= special_res;
                    rem_q <= '0;
                    quo_q <= (in_sgn && io.op1[31]) ? -io.op1 : io.op1;
                    dvs_q <= (in_sgn && io.op2[31]) ? -io.op2 : io.op2;
                    cnt_q <= '0;
                end
                S_MUL: res_q <= (f3_q == 3'b000) ? prod[31:0] : prod[63:32];
                S_DIV: begin
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) res_q <= div_res;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

RV32M multiply/divide unit for the execute stage of the 3-stage core. It consumes the ID/EX pipeline register outputs and recognises MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU. It computes the result over multiple cycles while asserting `hold` to freeze PC, IF/ID and ID/EX, then issues a single register-file write. The ALU path in `ex` ignores these encodings; the writeback mux ORs this unit's write port in when `rd_wen_o` is high.

## Interface
- Parameters: none (XLEN fixed at 32).
- sys_clk  in  1  clock, rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- inst  in  32  instruction from ID/EX (NOP after reset/flush).
- op1  in  32  rs1 value from ID/EX.
- op2  in  32  rs2 value from ID/EX.
- rd_addr  in  5  destination register from ID/EX.
- rd_wen  in  1  destination write enable from ID/EX.
- flush  in  1  jump/flush from ctrl; blocks a start in the same cycle.
- hold  out  1  stall request to ctrl (combinational).
- rd_data  out  32  result to register file.
- rd_addr_o  out  5  write address.
- rd_wen_o  out  1  write strobe, high for exactly one cycle per M-op.

## Operation
- M-op decode: opcode 7'b0110011, funct7 7'b0000001. funct3 selects the op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- FSM states are IDLE, MUL, DIV, DONE. Reset state is IDLE.
- IDLE: on M-op with flush=0, latch op1, op2, funct3, rd_addr and rd_wen, then:
  - MUL family → MUL.
  - DIV family with op2==0 → DONE with the special result.
  - Signed overflow (op1=0x80000000, op2=0xFFFFFFFF, DIV/REM) → DONE with the special result.
  - Any other division → DIV with count=0.
- MUL (1 cycle): register the 64-bit product.
  - Operands are sign- or zero-extended to 33 bits: MULH signed×signed, MULHSU signed×unsigned, MULHU unsigned×unsigned.
  - MUL returns product[31:0]; the others return product[63:32]. → DONE.
- DIV (32 cycles): restoring division on magnitudes.
  - Signed ops use |op1| and |op2|; unsigned ops use the raw values.
  - One quotient bit per cycle, MSB first, using a 5-bit counter.
  - At count==31 apply signs and go to DONE. Quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
- Special results:
  - Divide by zero: quotient 0xFFFFFFFF (DIV and DIVU); remainder = op1.
  - Overflow: quotient 0x80000000, remainder 0.
- DONE (1 cycle): drive rd_wen_o = latched rd_wen, rd_addr_o = latched rd_addr, rd_data = result. → IDLE unconditionally. DONE never restarts, even though inst still presents the same M-op this cycle.
- hold = (IDLE & M-op & !flush) | MUL | DIV. hold is 0 in DONE.
- flush only gates the start in IDLE. Once started, the op completes because it is the oldest instruction.
- Non-M instructions: no state change, hold=0, rd_wen_o=0.

## Timing
- Reset values: state IDLE, hold 0, rd_data 0, rd_addr_o 0, rd_wen_o 0, counter 0, all latches 0.
- Outputs rd_data, rd_addr_o and rd_wen_o are registered, or decoded from registered state. They are 0 outside DONE.
- MUL family: M-op seen in cycle T. hold high in T and T+1. Write in T+2. Next instruction is in ID/EX at T+3.
- Normal division: hold high T..T+32 (33 cycles). Write in T+33.
- Special-case division: hold high in T only. Write in T+1.
- Back-to-back M-ops: the second is detected in the cycle after DONE, with no lost or duplicated write.
- Reset asserted mid-operation: immediately returns to IDLE, hold=0, no write is issued, and the latched result is discarded.

## Test plan
- MUL op1=7, op2=0xFFFFFFFD (-3), rd=5 → hold high 2 cycles, then one write x5=0xFFFFFFEB.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV -7/2 → 0xFFFFFFFD, written 33 cycles after issue. REM -7/2 → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF. REM 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM of the same operands → 0. Each special case: hold 1 cycle, write in the next cycle.
- Reset asserted at cycle 10 of a DIV → hold drops asynchronously, rd_wen_o stays 0. A following MUL 3×4 → 12 completes normally.
- M-op with flush=1 → no hold, no write. An ADD instruction → hold=0, rd_wen_o=0. Back-to-back DIVU then MUL → exactly two writes, in order.
